serial_add_arb: RTL and testbench

SERIAL_ADD_ARB -- requirements
Module: serial_add_arb

---
 rtl/serial_add_arb.sv | 161 ++++++++++++++++
 tb/tb_serial_add_arb.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_arb.sv
// serial_add_arb: two-requester round-robin front end for a bit-serial
// adder built around an external 1-bit full-adder cell. One operation of
// WORD_W bits takes WORD_W RUN cycles, LSB first, and the result is then
// held in DONE until the consumer takes it.
// Optional feature macro: SERIAL_ADD_SUB_EN adds per-requester subtract
// inputs; subtraction is done as a + ~b + 1 through the same cell.
module serial_add_arb #(
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [WORD_W-1:0] req0_a,
    input  logic [WORD_W-1:0] req0_b,
    input  logic [WORD_W-1:0] req1_a,
    input  logic [WORD_W-1:0] req1_b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic              req0_sub,
    input  logic              req1_sub,
`endif
    output logic              fa_a,
    output logic              fa_b,
    output logic              fa_cin,
    input  logic              fa_sum,
    input  logic              fa_cout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WORD_W-1:0] res_data,
    output logic              res_id,
    output logic              busy
);

    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic              r_lastGrant;
    logic [CNT_W-1:0]  r_bitCnt;
    logic              r_carry;
    logic [WORD_W-1:0] r_opA;
    logic [WORD_W-1:0] r_opB;
    logic              r_sub;
    logic              r_id;
    logic [WORD_W-1:0] r_result;

    logic              w_grant1;
    logic              w_accept;
    logic              w_selSub;

    // Round-robin pick: a lone requester wins, a tie goes to whoever was not served last
    always_comb begin
        w_grant1 = req1_valid && (!req0_valid || !r_lastGrant);
    end

    // Subtract flag of the granted requester; without the feature it is always an add
    always_comb begin
`ifdef SERIAL_ADD_SUB_EN
        w_selSub = w_grant1 ? req1_sub : req0_sub;
`else
        w_selSub = 1'b0;
`endif
    end

    // Next-state logic plus handshake and full-adder drive; reset blocks any grant
    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        fa_a        = 1'b0;
        fa_b        = 1'b0;
        fa_cin      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!rst && (req0_valid || req1_valid)) begin
                    w_accept    = 1'b1;
                    req0_ready  = !w_grant1;
                    req1_ready  = w_grant1;
                    w_stateNext = RUN;
                end
            end
            RUN: begin
                fa_a   = r_opA[r_bitCnt];
                fa_b   = r_opB[r_bitCnt] ^ r_sub;
                fa_cin = r_carry;
                if (r_bitCnt == LAST_BIT) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Capture the granted operands so later requester changes cannot disturb the operation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opA       <= '0;
            r_opB       <= '0;
            r_sub       <= 1'b0;
            r_id        <= 1'b0;
            r_lastGrant <= 1'b1;
        end else if (w_accept) begin
            r_opA       <= w_grant1 ? req1_a : req0_a;
            r_opB       <= w_grant1 ? req1_b : req0_b;
            r_sub       <= w_selSub;
            r_id        <= w_grant1;
            r_lastGrant <= w_grant1;
        end
    end

    // Serial datapath: one result bit per RUN cycle, carry seeded with 1 for subtraction
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bitCnt <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_bitCnt <= '0;
            r_carry  <= w_selSub;
        end else if (r_state == RUN) begin
            r_result[r_bitCnt] <= fa_sum;
            r_carry            <= fa_cout;
            r_bitCnt           <= (r_bitCnt == LAST_BIT) ? '0 : r_bitCnt + 1'b1;
        end
    end

    // Status and result outputs come straight from state
    always_comb begin
        busy      = (r_state != IDLE);
        res_valid = (r_state == DONE);
        res_data  = r_result;
        res_id    = r_id;
    end

endmodule

// File: tb/tb_serial_add_arb.sv
// tb_serial_add_arb: scoreboard bench for serial_add_arb. A driver issues
// requests and predicts grants and results from plain arithmetic; a separate
// monitor pops expectations whenever a result is handed off.
// Define SERIAL_ADD_SUB_EN for both files to exercise subtraction.
module tb_serial_add_arb;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] data;
        logic         id;
    } expect_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         reqValid [2];
    logic [W-1:0] reqA [2];
    logic [W-1:0] reqB [2];
    logic         reqSub [2];
    logic         req0Ready;
    logic         req1Ready;
    logic         faA;
    logic         faB;
    logic         faCin;
    logic         faSum;
    logic         faCout;
    logic         resValid;
    logic         resReady;
    logic [W-1:0] resData;
    logic         resId;
    logic         busy;

    expect_t expQ[$];
    int      checks = 0;
    int      passes = 0;
    int      cycleCount = 0;
    int      acceptCycle = 0;
    bit      modelIdle = 1'b1;
    bit      modelLast = 1'b1;
    bit      pending [2];
    bit      randomMode = 1'b0;

    always #5 clk = ~clk;

    // Cycle counter used for latency measurement
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // External full-adder cell
    assign faSum  = faA ^ faB ^ faCin;
    assign faCout = (faA & faB) | (faA & faCin) | (faB & faCin);

    serial_add_arb #(.WORD_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (reqValid[0]),
        .req1_valid (reqValid[1]),
        .req0_ready (req0Ready),
        .req1_ready (req1Ready),
        .req0_a     (reqA[0]),
        .req0_b     (reqB[0]),
        .req1_a     (reqA[1]),
        .req1_b     (reqB[1]),
`ifdef SERIAL_ADD_SUB_EN
        .req0_sub   (reqSub[0]),
        .req1_sub   (reqSub[1]),
`endif
        .fa_a       (faA),
        .fa_b       (faB),
        .fa_cin     (faCin),
        .fa_sum     (faSum),
        .fa_cout    (faCout),
        .res_valid  (resValid),
        .res_ready  (resReady),
        .res_data   (resData),
        .res_id     (resId),
        .busy       (busy)
    );

    // Reference result: modular add or subtract
    function automatic logic [W-1:0] refResult(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        logic [W-1:0] r;
        r = sub ? (a - b) : (a + b);
        return r;
    endfunction

    // Reference arbitration: lone requester wins, tie goes to the one not served last
    function automatic int refGrant(input bit v0, input bit v1, input bit last);
        if (v0 && v1) return last ? 0 : 1;
        if (v0) return 0;
        return 1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    endtask

    // Drive requester and consumer inputs for the coming cycle
    task automatic applyStimulus();
        for (int n = 0; n < 2; n++) begin
            if (!pending[n]) begin
                if (randomMode && $urandom_range(0, 2) == 0) begin
                    pending[n] = 1'b1;
                    reqA[n] = W'($urandom);
                    reqB[n] = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
                    reqSub[n] = 1'($urandom_range(0, 1));
`endif
                end else begin
                    reqA[n] = W'($urandom);
                    reqB[n] = W'($urandom);
                end
            end
            reqValid[n] = pending[n];
        end
        if (randomMode) resReady = ($urandom_range(0, 3) != 0);
    endtask

    // One clock: check handshake outputs against the model at the falling edge
    task automatic stepCycle();
        int      g;
        expect_t e;
        applyStimulus();
        @(negedge clk);
        g = -1;
        if (modelIdle && !rst && (reqValid[0] || reqValid[1]))
            g = refGrant(reqValid[0], reqValid[1], modelLast);
        checkOutput("req0_ready", 64'(req0Ready), 64'(g == 0));
        checkOutput("req1_ready", 64'(req1Ready), 64'(g == 1));
        checkOutput("busy", 64'(busy), 64'(!modelIdle));
        if (modelIdle) checkOutput("fa_idle", 64'({faA, faB, faCin}), 64'd0);
        if (g >= 0) begin
            e.data = refResult(reqA[g], reqB[g], reqSub[g]);
            e.id   = (g == 1);
            expQ.push_back(e);
            modelLast   = (g == 1);
            modelIdle   = 1'b0;
            acceptCycle = cycleCount;
            pending[g]  = 1'b0;
        end else if (!modelIdle && resValid && resReady) begin
            modelIdle = 1'b1;
        end
        if (rst) begin
            modelIdle = 1'b1;
            modelLast = 1'b1;
            expQ.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_res_valid", 64'(resValid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_ready", 64'({req0Ready, req1Ready}), 64'd0);
        checkOutput("rst_fa", 64'({faA, faB, faCin}), 64'd0);
        checkOutput("rst_res_data", 64'(resData), 64'd0);
        checkOutput("rst_res_id", 64'(resId), 64'd0);
    endtask

    task automatic issue(input int n, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        pending[n] = 1'b1;
        reqA[n]    = a;
        reqB[n]    = b;
        reqSub[n]  = sub;
    endtask

    task automatic runUntilIdle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            stepCycle();
            done = modelIdle && !pending[0] && !pending[1] && (expQ.size() == 0);
        end
        checkOutput("drain_timeout", 64'(done), 64'd1);
    endtask

    // Monitor: compare every handed-off result and watch held results for stability
    initial begin
        bit           heldValid;
        logic [W-1:0] heldData;
        logic         heldId;
        expect_t      e;
        heldValid = 1'b0;
        heldData  = '0;
        heldId    = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                heldValid = 1'b0;
            end else if (resValid) begin
                if (!heldValid) begin
                    checkOutput("latency", 64'(cycleCount - acceptCycle), 64'(W + 1));
                end else begin
                    checkOutput("hold_data", 64'(resData), 64'(heldData));
                    checkOutput("hold_id", 64'(resId), 64'(heldId));
                end
                if (resReady) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        $display("[TB] FAIL unexpected_result: got 0x%0h expected none", resData);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("res_data", 64'(resData), 64'(e.data));
                        checkOutput("res_id", 64'(resId), 64'(e.id));
                    end
                    heldValid = 1'b0;
                end else begin
                    heldValid = 1'b1;
                    heldData  = resData;
                    heldId    = resId;
                end
            end else if (heldValid) begin
                checkOutput("res_valid_held", 64'(resValid), 64'd1);
                heldValid = 1'b0;
            end
        end
    end

    // Directed scenarios followed by a randomized run
    initial begin
        bit seen;
        rst = 1'b1;
        resReady = 1'b1;
        for (int n = 0; n < 2; n++) begin
            reqValid[n] = 1'b0;
            reqA[n]     = '0;
            reqB[n]     = '0;
            reqSub[n]   = 1'b0;
            pending[n]  = 1'b0;
        end
        stepCycle();
        stepCycle();
        checkResetOutputs();
        rst = 1'b0;

        $display("[TB] tie after reset, then a second tie");
        issue(0, 16'h1234, 16'h1111, 1'b0);
        issue(1, 16'h0F0F, 16'h00F1, 1'b0);
        runUntilIdle(100);
        issue(0, 16'h0102, 16'h0304, 1'b0);
        issue(1, 16'h1111, 16'h2222, 1'b0);
        runUntilIdle(100);

        $display("[TB] wrap-around add");
        issue(0, 16'hFFFF, 16'h0001, 1'b0);
        runUntilIdle(50);

        $display("[TB] consumer stall in DONE");
        resReady = 1'b0;
        issue(1, 16'hA5A5, 16'h1357, 1'b0);
        issue(0, 16'h7FFF, 16'h7FFF, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 3 * W && !seen; i++) begin
            stepCycle();
            seen = resValid;
        end
        checkOutput("stall_reach_done", 64'(seen), 64'd1);
        repeat (10) stepCycle();
        resReady = 1'b1;
        runUntilIdle(100);

        $display("[TB] reset during RUN");
        issue(0, 16'h4321, 16'h1111, 1'b0);
        stepCycle();
        repeat (7) stepCycle();
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkResetOutputs();
        for (int i = 0; i < 20; i++) begin
            stepCycle();
            if (i % 5 == 0) checkOutput("no_result_after_reset", 64'(resValid), 64'd0);
        end
        issue(0, 16'h0003, 16'h0004, 1'b0);
        runUntilIdle(50);

`ifdef SERIAL_ADD_SUB_EN
        $display("[TB] subtraction");
        issue(1, 16'h0000, 16'h0001, 1'b1);
        runUntilIdle(50);
        issue(1, 16'h8000, 16'h8000, 1'b1);
        runUntilIdle(50);
`endif

        $display("[TB] randomized traffic");
        randomMode = 1'b1;
        repeat (600) stepCycle();
        randomMode = 1'b0;
        resReady = 1'b1;
        runUntilIdle(200);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
